// File: rtl/vcr_pkg.sv
// Shared types and constants for the VCR byte-strobe master.
// Firmware and bench pick the register addresses up from here too.
package vcr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_A_SETUP,
    ST_A_PULSE,
    ST_A_HOLD,
    ST_TURN,
    ST_D_SETUP,
    ST_D_PULSE,
    ST_D_HOLD
  } vcr_state_e;

  localparam int SETUP_CYC_DEF = 2;
  localparam int PULSE_CYC_DEF = 2;
  localparam int HOLD_CYC_DEF  = 2;
  localparam int TURN_CYC_DEF  = 2;

  localparam logic [7:0] VCR_ADDR_FIFO = 8'h01;
  localparam logic [7:0] VCR_ADDR_CTRL = 8'h8B;

  // Terminal phase-counter value for a phase lasting n cycles.
  function automatic logic [3:0] last_cyc(input int n);
    return 4'(n - 1);
  endfunction

endpackage

// File: rtl/vcr_if.sv
// Command/data/pin bundle of the VCR master; 'master' is the controller side,
// 'slave' the side that issues commands and models the FPGA pins.
interface vcr_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_rd;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_len;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [7:0] pc_in;
  logic [7:0] pc_out;
  logic       pc_oe;
  logic       PA0;
  logic       PA1;
  logic       PA7;
  logic       busy;

  modport master (
    input  cmd_valid, cmd_rd, cmd_addr, cmd_len, wr_data, wr_valid, pc_in,
    output cmd_ready, wr_ready, rd_data, rd_valid, pc_out, pc_oe, PA0, PA1, PA7, busy
  );

  modport slave (
    output cmd_valid, cmd_rd, cmd_addr, cmd_len, wr_data, wr_valid, pc_in,
    input  cmd_ready, wr_ready, rd_data, rd_valid, pc_out, pc_oe, PA0, PA1, PA7, busy
  );
endinterface

// File: rtl/vcr_strobe_timer.sv
// Phase counter for the strobe FSM: restarts on clr, advances on en,
// and flags the last cycle of each configurable phase.
module vcr_strobe_timer
  import vcr_pkg::*;
#(
  parameter int SETUP_CYC = SETUP_CYC_DEF,
  parameter int PULSE_CYC = PULSE_CYC_DEF,
  parameter int HOLD_CYC  = HOLD_CYC_DEF,
  parameter int TURN_CYC  = TURN_CYC_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic setup_done,
  output logic pulse_done,
  output logic hold_done,
  output logic turn_done
);

  localparam logic [3:0] SETUP_LAST = last_cyc(SETUP_CYC);
  localparam logic [3:0] PULSE_LAST = last_cyc(PULSE_CYC);
  localparam logic [3:0] HOLD_LAST  = last_cyc(HOLD_CYC);
  localparam logic [3:0] TURN_LAST  = last_cyc(TURN_CYC);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 4'd0;
    end else if (en) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign setup_done = (cnt_q == SETUP_LAST);
  assign pulse_done = (cnt_q == PULSE_LAST);
  assign hold_done  = (cnt_q == HOLD_LAST);
  assign turn_done  = (cnt_q == TURN_LAST);

endmodule

// File: rtl/vcr_master.sv
// VCR bus master: address phase on PA0, data bursts on PA1, PA7 selects the
// FPGA-to-host direction with a turnaround phase around every read burst.
module vcr_master
  import vcr_pkg::*;
#(
  parameter int SETUP_CYC = SETUP_CYC_DEF,
  parameter int PULSE_CYC = PULSE_CYC_DEF,
  parameter int HOLD_CYC  = HOLD_CYC_DEF,
  parameter int TURN_CYC  = TURN_CYC_DEF
) (
  input logic   IFCLK,
  input logic   RESET_N,
  vcr_if.master bus
);

  vcr_state_e state_q, state_d;
  logic       rd_q, rd_d;
  logic [7:0] rem_q, rem_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic       rd_valid_q, rd_valid_d;
  logic       have_byte_q, have_byte_d;
  logic       pa0_q, pa0_d;
  logic       pa1_q, pa1_d;
  logic       pa7_q, pa7_d;
  logic       oe_q, oe_d;
  logic       cmd_ready_q, cmd_ready_d;

  logic wr_fire;
  logic in_addr, in_data;
  logic tmr_clr, tmr_en;
  logic setup_done, pulse_done, hold_done, turn_done;

  vcr_strobe_timer #(
    .SETUP_CYC (SETUP_CYC),
    .PULSE_CYC (PULSE_CYC),
    .HOLD_CYC  (HOLD_CYC),
    .TURN_CYC  (TURN_CYC)
  ) u_timer (
    .clk        (IFCLK),
    .rst_n      (RESET_N),
    .clr        (tmr_clr),
    .en         (tmr_en),
    .setup_done (setup_done),
    .pulse_done (pulse_done),
    .hold_done  (hold_done),
    .turn_done  (turn_done)
  );

  // A write byte is taken in the first D_SETUP cycle that sees wr_valid;
  // that cycle already counts as the first setup cycle.
  assign wr_fire = (state_q == ST_D_SETUP) && !rd_q && !have_byte_q && bus.wr_valid;

  always_comb begin
    state_d    = state_q;
    rd_d       = rd_q;
    rem_d      = rem_q;
    pc_d       = pc_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          state_d = ST_A_SETUP;
          rd_d    = bus.cmd_rd;
          pc_d    = bus.cmd_addr;
          rem_d   = bus.cmd_len;
        end
      end
      ST_A_SETUP: if (setup_done) state_d = ST_A_PULSE;
      ST_A_PULSE: if (pulse_done) state_d = ST_A_HOLD;
      ST_A_HOLD: begin
        if (hold_done) begin
          if (rem_q == 8'd0)  state_d = ST_IDLE;
          else if (rd_q)      state_d = ST_TURN;
          else                state_d = ST_D_SETUP;
        end
      end
      ST_TURN: begin
        if (turn_done) state_d = (rem_q == 8'd0) ? ST_IDLE : ST_D_SETUP;
      end
      ST_D_SETUP: begin
        if (rd_q) begin
          if (setup_done) begin
            rd_data_d  = bus.pc_in;
            rd_valid_d = 1'b1;
            state_d    = ST_D_PULSE;
          end
        end else begin
          if (wr_fire) pc_d = bus.wr_data;
          if ((have_byte_q || wr_fire) && setup_done) state_d = ST_D_PULSE;
        end
      end
      ST_D_PULSE: if (pulse_done) state_d = ST_D_HOLD;
      ST_D_HOLD: begin
        if (hold_done) begin
          rem_d = rem_q - 8'd1;
          if (rem_q != 8'd1) state_d = ST_D_SETUP;
          else if (rd_q)     state_d = ST_TURN;
          else               state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Pin controls derive from the next state so the flops line up with state_q.
    in_addr     = state_d inside {ST_A_SETUP, ST_A_PULSE, ST_A_HOLD};
    in_data     = state_d inside {ST_D_SETUP, ST_D_PULSE, ST_D_HOLD};
    pa0_d       = (state_d == ST_A_PULSE);
    pa1_d       = (state_d == ST_D_PULSE);
    pa7_d       = rd_d && (in_data || ((state_d == ST_TURN) && (rem_d != 8'd0)));
    oe_d        = in_addr || (in_data && !rd_d);
    have_byte_d = (state_d == ST_D_SETUP) && (have_byte_q || wr_fire);
    cmd_ready_d = (state_d == ST_IDLE);

    tmr_clr = (state_d != state_q);
    tmr_en  = !((state_q == ST_D_SETUP) && !rd_q && !have_byte_q && !bus.wr_valid);
  end

  always_ff @(posedge IFCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= ST_IDLE;
      rd_q        <= 1'b0;
      rem_q       <= 8'd0;
      pc_q        <= 8'd0;
      rd_data_q   <= 8'd0;
      rd_valid_q  <= 1'b0;
      have_byte_q <= 1'b0;
      pa0_q       <= 1'b0;
      pa1_q       <= 1'b0;
      pa7_q       <= 1'b0;
      oe_q        <= 1'b0;
      cmd_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_q        <= rd_d;
      rem_q       <= rem_d;
      pc_q        <= pc_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      have_byte_q <= have_byte_d;
      pa0_q       <= pa0_d;
      pa1_q       <= pa1_d;
      pa7_q       <= pa7_d;
      oe_q        <= oe_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.wr_ready  = wr_fire;
  assign bus.rd_data   = rd_data_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.pc_out    = wr_fire ? bus.wr_data : pc_q;
  assign bus.pc_oe     = oe_q;
  assign bus.PA0       = pa0_q;
  assign bus.PA1       = pa1_q;
  assign bus.PA7       = pa7_q;
  assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_vcr_master.sv
// Directed bench for vcr_master: write, read, address-only, stalled write,
// mid-burst reset and back-to-back commands against hand-computed numbers.
module tb_vcr_master;
  import vcr_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vcr_if bus();

  vcr_master #(
    .SETUP_CYC (2),
    .PULSE_CYC (2),
    .HOLD_CYC  (2),
    .TURN_CYC  (2)
  ) u_dut (
    .IFCLK   (clk),
    .RESET_N (rst_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pin monitor, sampled mid-cycle.
  int pa0_cnt = 0, pa1_cnt = 0, pa7_cyc = 0, overlap_cnt = 0, oe_viol_cnt = 0;
  int pa0_w = 0, pa1_w = 0, pa0_w_last = 0, pa1_w_last = 0;
  logic pa0_prev = 1'b0, pa1_prev = 1'b0;
  logic [7:0] pa0_pc[$];
  logic [7:0] pa1_pc[$];
  logic [7:0] rd_q[$];

  always @(negedge clk) begin
    if (bus.PA0 && !pa0_prev) begin pa0_cnt++; pa0_pc.push_back(bus.pc_out); pa0_w = 0; end
    if (bus.PA0) pa0_w++; else if (pa0_prev) pa0_w_last = pa0_w;
    if (bus.PA1 && !pa1_prev) begin pa1_cnt++; pa1_pc.push_back(bus.pc_out); pa1_w = 0; end
    if (bus.PA1) pa1_w++; else if (pa1_prev) pa1_w_last = pa1_w;
    if (bus.PA7) pa7_cyc++;
    if (bus.PA0 && bus.PA1) overlap_cnt++;
    if (bus.pc_oe && bus.PA7) oe_viol_cnt++;
    if (bus.rd_valid) rd_q.push_back(bus.rd_data);
    pa0_prev = bus.PA0;
    pa1_prev = bus.PA1;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      assert (!(bus.PA0 && bus.PA1)) else $error("PA0 and PA1 high together");
      assert (!(bus.pc_oe && bus.PA7)) else $error("pc_oe high while PA7 high");
    end
  end

  // FPGA FIFO model: each PA1 pulse advances the read pointer.
  int rd_base = 0;
  assign bus.pc_in = 8'(32'hA0 + pa1_cnt - rd_base);

  // Write-data source with an optional stall after a given byte count.
  logic [7:0] wr_q[$];
  int popped = 0, stall_left = 0;
  int stall_after = -1, stall_len = 0;
  logic fire;

  initial begin
    bus.wr_valid = 1'b0;
    bus.wr_data  = 8'h00;
    forever begin
      @(negedge clk);
      fire = bus.wr_valid && bus.wr_ready;
      @(posedge clk);
      #1;
      if (fire) begin
        void'(wr_q.pop_front());
        popped++;
        if (popped == stall_after) stall_left = stall_len;
      end else if (stall_left > 0) begin
        stall_left--;
      end
      bus.wr_valid = (wr_q.size() > 0) && (stall_left == 0);
      bus.wr_data  = (wr_q.size() > 0) ? wr_q[0] : 8'h00;
    end
  end

  task automatic do_cmd(input logic rd, input logic [7:0] addr, input logic [7:0] len, output int cyc);
    int n = 0;
    @(negedge clk);
    bus.cmd_rd    = rd;
    bus.cmd_addr  = addr;
    bus.cmd_len   = len;
    bus.cmd_valid = 1'b1;
    while (!bus.cmd_ready && n < 100) begin @(negedge clk); n++; end
    check_eq("cmd_accept", 32'(bus.cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    cyc = 0;
    @(negedge clk);
    while (bus.busy && cyc < 5000) begin cyc++; @(negedge clk); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int cyc, b0, b1, b7, bo, q0, q1, rb, n, idle_cyc;

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_rd    = 1'b0;
    bus.cmd_addr  = 8'h00;
    bus.cmd_len   = 8'h00;

    // Reset state
    #2;
    check_eq("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    check_eq("rst_busy",      32'(bus.busy),      32'd0);
    check_eq("rst_pins",      {28'd0, bus.PA0, bus.PA1, bus.PA7, bus.pc_oe}, 32'd0);
    check_eq("rst_pc_out",    32'(bus.pc_out),    32'd0);
    check_eq("rst_rd",        {23'd0, bus.rd_valid, bus.rd_data}, 32'd0);
    check_eq("rst_wr_ready",  32'(bus.wr_ready),  32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("ready_before_clk", 32'(bus.cmd_ready), 32'd0);
    @(negedge clk);
    check_eq("ready_after_clk", 32'(bus.cmd_ready), 32'd1);

    // Single-byte write, data already waiting
    wr_q.push_back(8'h5A);
    @(negedge clk); @(negedge clk);
    b0 = pa0_cnt; b1 = pa1_cnt; b7 = pa7_cyc; q0 = pa0_pc.size(); q1 = pa1_pc.size();
    do_cmd(1'b0, VCR_ADDR_CTRL, 8'd1, cyc);
    check_eq("wr1_busy_cyc", cyc, 12);
    check_eq("wr1_pa0_cnt", pa0_cnt - b0, 1);
    check_eq("wr1_pa0_pc", 32'(pa0_pc[q0]), 32'h8B);
    check_eq("wr1_pa0_w", pa0_w_last, 2);
    check_eq("wr1_pa1_cnt", pa1_cnt - b1, 1);
    check_eq("wr1_pa1_pc", 32'(pa1_pc[q1]), 32'h5A);
    check_eq("wr1_pa1_w", pa1_w_last, 2);
    check_eq("wr1_pa7", pa7_cyc - b7, 0);

    // Three-byte read from the FIFO model
    rd_base = pa1_cnt;
    b0 = pa0_cnt; b1 = pa1_cnt; b7 = pa7_cyc; bo = oe_viol_cnt; rb = rd_q.size(); q0 = pa0_pc.size();
    do_cmd(1'b1, VCR_ADDR_FIFO, 8'd3, cyc);
    check_eq("rd3_busy_cyc", cyc, 28);
    check_eq("rd3_pa0_pc", 32'(pa0_pc[q0]), 32'h01);
    check_eq("rd3_rd_cnt", rd_q.size() - rb, 3);
    for (int i = 0; i < 3; i++) begin
      if (rd_q.size() > rb + i) check_eq($sformatf("rd3_data%0d", i), 32'(rd_q[rb + i]), 32'hA0 + i);
    end
    check_eq("rd3_pa1_cnt", pa1_cnt - b1, 3);
    check_eq("rd3_pa7_cyc", pa7_cyc - b7, 20);
    check_eq("rd3_oe_pa7", oe_viol_cnt - bo, 0);

    // Four-byte write with a 10-cycle wr_valid gap before byte 3
    wr_q.push_back(8'h11); wr_q.push_back(8'h22); wr_q.push_back(8'h33); wr_q.push_back(8'h44);
    stall_after = popped + 2;
    stall_len   = 10;
    @(negedge clk); @(negedge clk);
    b1 = pa1_cnt; q1 = pa1_pc.size();
    do_cmd(1'b0, VCR_ADDR_CTRL, 8'd4, cyc);
    stall_after = -1;
    check_eq("wr4_busy_cyc", cyc, 35);
    check_eq("wr4_pa1_cnt", pa1_cnt - b1, 4);
    for (int i = 0; i < 4; i++) begin
      if (pa1_pc.size() > q1 + i) check_eq($sformatf("wr4_data%0d", i), 32'(pa1_pc[q1 + i]), 32'h11 * (i + 1));
    end

    // Address-only
    b0 = pa0_cnt; b1 = pa1_cnt;
    do_cmd(1'b0, 8'h40, 8'd0, cyc);
    check_eq("ao_busy_cyc", cyc, 6);
    check_eq("ao_pa0_cnt", pa0_cnt - b0, 1);
    check_eq("ao_pa1_cnt", pa1_cnt - b1, 0);
    check_eq("ao_ready", 32'(bus.cmd_ready), 32'd1);

    // Maximum length read
    rd_base = pa1_cnt;
    b1 = pa1_cnt; rb = rd_q.size();
    do_cmd(1'b1, VCR_ADDR_FIFO, 8'd255, cyc);
    check_eq("rd255_busy_cyc", cyc, 1540);
    check_eq("rd255_rd_cnt", rd_q.size() - rb, 255);
    check_eq("rd255_pa1_cnt", pa1_cnt - b1, 255);
    if (rd_q.size() >= rb + 255) check_eq("rd255_last", 32'(rd_q[rb + 254]), 32'h9E);

    // Reset during D_PULSE of byte 2 of 5
    for (int i = 1; i <= 5; i++) wr_q.push_back(8'(i));
    @(negedge clk); @(negedge clk);
    b0 = pa0_cnt; b1 = pa1_cnt; rb = rd_q.size();
    bus.cmd_rd = 1'b0; bus.cmd_addr = 8'h8B; bus.cmd_len = 8'd5; bus.cmd_valid = 1'b1;
    n = 0;
    while (!bus.cmd_ready && n < 100) begin @(negedge clk); n++; end
    @(posedge clk); #1; bus.cmd_valid = 1'b0;
    n = 0;
    while (!(bus.PA1 && (pa1_cnt - b1 == 2)) && n < 500) begin @(negedge clk); n++; end
    check_eq("rst_mid_reached", 32'(n < 500), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_pa1", 32'(bus.PA1), 32'd0);
    check_eq("rst_mid_oe", 32'(bus.pc_oe), 32'd0);
    check_eq("rst_mid_busy", 32'(bus.busy), 32'd0);
    wr_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check_eq("rst_mid_pa1_cnt", pa1_cnt - b1, 2);
    check_eq("rst_mid_pa0_cnt", pa0_cnt - b0, 1);
    check_eq("rst_mid_rd_cnt", rd_q.size() - rb, 0);
    b0 = pa0_cnt;
    do_cmd(1'b0, 8'h22, 8'd0, cyc);
    check_eq("rst_mid_next_busy", cyc, 6);
    check_eq("rst_mid_next_pa0", pa0_cnt - b0, 1);

    // Back-to-back address-only commands with cmd_valid held
    b0 = pa0_cnt; q0 = pa0_pc.size();
    @(negedge clk);
    bus.cmd_rd = 1'b0; bus.cmd_addr = 8'h10; bus.cmd_len = 8'd0; bus.cmd_valid = 1'b1;
    n = 0;
    while (!bus.cmd_ready && n < 100) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    bus.cmd_addr = 8'h20;
    n = 0;
    @(negedge clk);
    while (bus.busy && n < 100) begin @(negedge clk); n++; end
    idle_cyc = 0;
    while (!bus.busy && idle_cyc < 100) begin idle_cyc++; @(negedge clk); end
    bus.cmd_valid = 1'b0;
    check_eq("b2b_idle_cyc", idle_cyc, 1);
    n = 0;
    while (bus.busy && n < 100) begin @(negedge clk); n++; end
    check_eq("b2b_pa0_cnt", pa0_cnt - b0, 2);
    if (pa0_pc.size() >= q0 + 2) begin
      check_eq("b2b_addr0", 32'(pa0_pc[q0]), 32'h10);
      check_eq("b2b_addr1", 32'(pa0_pc[q0 + 1]), 32'h20);
    end

    check_eq("pa0_pa1_overlap", overlap_cnt, 0);
    check_eq("oe_while_pa7", oe_viol_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
